// File: rtl/unit_writeback_buffer.sv
`default_nettype none
// ============================================================================
// unit_writeback_buffer
//   In-order FIFO of completed {id, rd} results offered to writeback/commit.
//   Rev 1.0
// ============================================================================
module unit_writeback_buffer #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 3,
  parameter int XLEN     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     result_valid,
  input  logic [ID_WIDTH-1:0]      result_id,
  input  logic [XLEN-1:0]          result_data,
  output logic                     result_ready,
  output logic                     wb_done,
  output logic [ID_WIDTH-1:0]      wb_id,
  output logic [XLEN-1:0]          wb_rd,
  input  logic                     wb_ack,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);

  logic [ID_WIDTH-1:0] id_mem_q   [DEPTH];
  logic [XLEN-1:0]     data_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             w_push, w_pop;

  // Ready and done are decoded from the registered count only, so neither
  // depends combinationally on result_valid or wb_ack.
  assign result_ready = (occ_q != C_CNT_FULL);
  assign wb_done      = (occ_q != '0);
  assign w_push       = result_valid & result_ready;
  assign w_pop        = wb_ack & wb_done;

  assign wb_id     = wb_done ? id_mem_q[rd_ptr_q]   : '0;
  assign wb_rd     = wb_done ? data_mem_q[rd_ptr_q] : '0;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    if (w_push) begin
      wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (w_push && !w_pop) begin
      occ_d = occ_q + 1'b1;
    end else if (w_pop && !w_push) begin
      occ_d = occ_q - 1'b1;
    end
    if (result_valid && !result_ready) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is validated by the pointers/count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      id_mem_q[wr_ptr_q]   <= result_id;
      data_mem_q[wr_ptr_q] <= result_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unit_writeback_buffer.sv
`default_nettype none
// Testbench for unit_writeback_buffer: directed + random steps checked
// against a queue-based reference model.
module tb_unit_writeback_buffer;

  localparam int DEPTH    = 4;
  localparam int ID_WIDTH = 3;
  localparam int XLEN     = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   result_valid;
  logic [ID_WIDTH-1:0]    result_id;
  logic [XLEN-1:0]        result_data;
  logic                   result_ready;
  logic                   wb_done;
  logic [ID_WIDTH-1:0]    wb_id;
  logic [XLEN-1:0]        wb_rd;
  logic                   wb_ack;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   overflow;

  unit_writeback_buffer #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .result_valid(result_valid), .result_id(result_id), .result_data(result_data),
    .result_ready(result_ready),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
    .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: entries in push order, plus the sticky drop flag.
  logic [ID_WIDTH+XLEN-1:0] mq[$];
  logic                     m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic                exp_done;
    logic [ID_WIDTH-1:0] exp_id;
    logic [XLEN-1:0]     exp_rd;
    exp_done = (mq.size() != 0);
    exp_id   = exp_done ? mq[0][ID_WIDTH+XLEN-1:XLEN] : '0;
    exp_rd   = exp_done ? mq[0][XLEN-1:0] : '0;
    chk({tag, ".wb_done"},      64'(wb_done),      64'(exp_done));
    chk({tag, ".wb_id"},        64'(wb_id),        64'(exp_id));
    chk({tag, ".wb_rd"},        64'(wb_rd),        64'(exp_rd));
    chk({tag, ".occupancy"},    64'(occupancy),    64'(mq.size()));
    chk({tag, ".overflow"},     64'(overflow),     64'(m_ovf));
    chk({tag, ".result_ready"}, 64'(result_ready), 64'(mq.size() != DEPTH));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, check.
  task automatic step(input string tag, input logic rv, input logic [ID_WIDTH-1:0] id,
                      input logic [XLEN-1:0] d, input logic ack);
    logic full, push, pop;
    result_valid = rv;
    result_id    = id;
    result_data  = d;
    wb_ack       = ack;
    full = (mq.size() == DEPTH);
    push = rv && !full;
    pop  = ack && (mq.size() != 0);
    if (rv && full) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back({id, d});
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1;
    result_valid = 1'b0;
    result_id = '0;
    result_data = '0;
    wb_ack = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    check_model("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_model("reset_held");
    rst = 1'b0;

    // Single result held under backpressure, then retired.
    step("single_push", 1'b1, 3'd2, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("single_hold", 1'b0, 3'd0, 32'h0, 1'b0);
      chk("single_hold.id_const", 64'(wb_id), 64'd2);
      chk("single_hold.rd_const", 64'(wb_rd), 64'hDEADBEEF);
    end
    step("single_ack", 1'b0, 3'd0, 32'h0, 1'b1);
    chk("single_ack.done_const", 64'(wb_done), 64'd0);

    // Fill in order, then drain one per cycle.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 3'(i), 32'h1000 + 32'(i), 1'b0);
    chk("fill.ready_const", 64'(result_ready), 64'd0);
    chk("fill.occ_const", 64'(occupancy), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain.order_id", 64'(wb_id), 64'(i));
      step("drain", 1'b0, 3'd0, 32'h0, 1'b1);
    end

    // Overflow while full, including a full+ack cycle that still drops.
    for (int i = 0; i < 4; i++) step("ovf_fill", 1'b1, 3'(i), 32'h2000 + 32'(i), 1'b0);
    step("ovf_drop", 1'b1, 3'd5, 32'h5555_5555, 1'b0);
    chk("ovf_drop.flag_const", 64'(overflow), 64'd1);
    step("ovf_full_ack", 1'b1, 3'd5, 32'h5555_5556, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain.no_id5", 64'(wb_id == 3'd5), 64'd0);
      step("ovf_drain", 1'b0, 3'd0, 32'h0, 1'b1);
    end

    // Push into empty with ack: ack ignored, entry appears next cycle.
    step("empty_push_ack", 1'b1, 3'd7, 32'h7777_0007, 1'b1);
    chk("empty_push_ack.id_const", 64'(wb_id), 64'd7);
    chk("empty_push_ack.occ_const", 64'(occupancy), 64'd1);

    // Streaming push+ack from occupancy 1 across several pointer wraps.
    for (int i = 0; i < 16; i++) begin
      step("stream", 1'b1, 3'(i), $urandom, 1'b1);
      chk("stream.occ_const", 64'(occupancy), 64'd1);
    end

    // Random traffic, first biased toward filling, then toward draining.
    for (int i = 0; i < 300; i++) begin
      step("random", 1'($urandom_range(0, 1)), 3'($urandom), $urandom,
           (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    // Reset mid-operation, between edges, with a push pending.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 3'(i + 1), 32'h3000 + 32'(i), 1'b0);
    result_valid = 1'b1;
    result_id    = 3'd4;
    wb_ack       = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_model("mid_reset");
    @(posedge clk); #1;
    check_model("mid_reset_edge");
    result_valid = 1'b0;
    wb_ack = 1'b0;
    rst = 1'b0;
    step("post_rst_push", 1'b1, 3'd6, 32'hCAFE_F00D, 1'b0);
    chk("post_rst_push.occ_const", 64'(occupancy), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
